// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and default constants for the UART receive path.
//   rx_state_t        : frame controller states
//   UART_CLKS_PER_BIT : default clk cycles per serial bit
//   UART_DATA_BITS    : default data bits per frame
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_CHK = 2'd1,
        RECV      = 2'd2,
        STOP      = 2'd3
    } rx_state_t;

    localparam int UART_CLKS_PER_BIT = 10;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/rx_bit_timer.sv
// -----------------------------------------------------------------------------
// rx_bit_timer
// Bit-period counter. After a clear it holds 0; while enabled it counts
// 1..CLKS_PER_BIT and wraps back to 1. One instance serves the half-bit,
// data-bit and stop-bit periods of a frame.
// Ports:
//   clk, n_rst : clock, async active-low reset
//   en         : advance the count this edge
//   clr        : force the count to 0 (wins over en)
//   cnt        : current count
//   tc_m2      : cnt == CLKS_PER_BIT-2 (next enabled edge reaches terminal-1)
//   tc_m1      : cnt == CLKS_PER_BIT-1 (next enabled edge reaches terminal)
// -----------------------------------------------------------------------------
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_m2,
    output logic             tc_m1
);

    localparam logic [CNT_W-1:0] TOP    = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TOP_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TOP_M2 = CNT_W'(CLKS_PER_BIT - 2);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TOP) ? CNT_W'(1) : cnt + CNT_W'(1);
        end
    end

    assign tc_m2 = (cnt == TOP_M2);
    assign tc_m1 = (cnt == TOP_M1);

endmodule

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
// UART receive frame controller. Qualifies the start bit at mid-bit, strobes
// the external shift register once per data bit at mid-bit, checks the stop
// bit and then either loads the RX buffer or flags a framing error.
// Ports:
//   clk                : system clock
//   n_rst              : async active-low reset
//   start_bit_detected : one-cycle pulse from the start bit detector
//   serial_sync        : synchronized serial line
//   shift_strobe       : shifter captures serial_sync on the edge ending this pulse
//   load_buffer        : one-cycle pulse, RX buffer latches shifter contents
//   framing_error      : level, set on a bad stop bit, cleared by next good start
//   busy               : high whenever a frame is in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start_bit_detected
// START_CHK | counting to mid start bit, rejecting glitches
// RECV      | one bit period per data bit, strobe just before each capture
// STOP      | one bit period, then sample the stop bit
// -----------------------------------------------------------------------------
module rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_bit_detected,
    input  logic serial_sync,
    output logic shift_strobe,
    output logic load_buffer,
    output logic framing_error,
    output logic busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t         state;
    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     clk_cnt;
    logic              tc_m2;
    logic              tc_m1;
    logic              half_hit;
    logic              capture;
    logic              last_capture;
    logic              stop_hit;
    logic              tmr_en;
    logic              tmr_clr;

    // The timer is cleared at every period boundary so each phase starts at 0;
    // in IDLE it is held at 0 so START_CHK always begins from a known count.
    assign half_hit     = (state == START_CHK) && (clk_cnt == HALF_M1);
    assign capture      = (state == RECV) && tc_m1;
    assign last_capture = capture && (bit_cnt == LAST_BIT);
    assign stop_hit     = (state == STOP) && tc_m1;
    assign tmr_en       = (state != IDLE);
    assign tmr_clr      = (state == IDLE) || half_hit || last_capture;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CW)
    ) u_bit_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (tmr_en),
        .clr   (tmr_clr),
        .cnt   (clk_cnt),
        .tc_m2 (tc_m2),
        .tc_m1 (tc_m1)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_strobe  <= 1'b0;
            load_buffer   <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Strobe rises one edge before the capture edge so the shifter
            // samples the line exactly at mid-bit.
            shift_strobe <= (state == RECV) && tc_m2;
            load_buffer  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_bit_detected) begin
                        state   <= START_CHK;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                START_CHK: begin
                    if (half_hit) begin
                        if (serial_sync) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state         <= RECV;
                            framing_error <= 1'b0;
                        end
                    end
                end
                RECV: begin
                    if (capture) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        if (last_capture) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (stop_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (serial_sync) begin
                            load_buffer <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side frame controller for the UART RX peripheral, directly downstream of the start bit detector.
- Consumes the detector's one-cycle start_bit_detected pulse and the synchronized serial line.
- Times each bit at mid-bit using an internal oversampling counter and strobes the RX data shift register DATA_BITS times.
- Checks the stop bit, then either pulses load_buffer to the RX data buffer or raises framing_error.

Parameters:
- CLKS_PER_BIT, 10, clk cycles per serial bit; legal range >= 4; HALF = CLKS_PER_BIT/2 (floor).
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start_bit_detected  input  1  one-cycle pulse from the start bit detector (falling edge seen on the synchronized line).
- serial_sync  input  1  synchronized serial line, same sample stream the detector uses.
- shift_strobe  output  1  one-cycle pulse; downstream shift register captures serial_sync on the edge that ends this pulse.
- load_buffer  output  1  one-cycle pulse; the RX buffer latches the shift register contents.
- framing_error  output  1  level; set on a bad stop bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset n_rst is asynchronous, active-low.
- Reset (async, any time, including mid-frame): state IDLE, counters 0, all outputs 0.
- All outputs are registered (Moore). No combinational input-to-output path.
- Timing reference: offset 0 is the clk edge at which start_bit_detected is sampled high in IDLE.
- States: IDLE, START_CHK, RECV, STOP.
  - IDLE -> START_CHK on start_bit_detected; clk_cnt <= 0, bit_cnt <= 0.
  - START_CHK: clk_cnt increments each edge. At edge offset HALF, serial_sync is sampled.
    - If sampled 1 (glitch): return to IDLE. No strobes; framing_error unchanged.
    - If sampled 0: go to RECV, clk_cnt <= 0, framing_error <= 0.
  - RECV: clk_cnt counts 1..CLKS_PER_BIT, then wraps to 1.
    - shift_strobe is set at the edge where clk_cnt reaches CLKS_PER_BIT-1, so the shifter captures at the count-CLKS_PER_BIT edge.
    - Strobe k (k = 0..DATA_BITS-1) is high between edges HALF+CLKS_PER_BIT*(k+1)-1 and HALF+CLKS_PER_BIT*(k+1).
    - bit_cnt increments on each capture edge. After capture DATA_BITS: go to STOP, clk_cnt <= 0.
  - STOP: after CLKS_PER_BIT more edges, serial_sync is sampled at edge offset HALF+CLKS_PER_BIT*(DATA_BITS+1). Then go to IDLE.
    - At that same edge: if the sample is 1, load_buffer <= 1 for exactly one cycle.
    - If the sample is 0, framing_error <= 1 and no load_buffer pulse.
- framing_error holds until the next frame passes START_CHK, or until reset.
- start_bit_detected is ignored outside IDLE. This includes a pulse coincident with the STOP sample edge; the next frame is accepted from IDLE onward.
- busy = (state != IDLE).
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT+1) bits; bit_cnt is $clog2(DATA_BITS+1) bits; no overflow is reachable.
- shift_strobe, load_buffer and framing_error rising are mutually exclusive in any cycle.

Decomposition:
- Shared package uart_rx_pkg holds:
  - rx_state_t enum {IDLE, START_CHK, RECV, STOP}.
  - Default constants UART_CLKS_PER_BIT = 10 and UART_DATA_BITS = 8.
- One natural sub-module: rx_bit_timer, a CLKS_PER_BIT wrap counter with enable/clear and a terminal-minus-one pulse. It is instantiated once and reused for the half-bit, data-bit and stop-bit periods.
- The FSM, bit counter and output registers live in rx_frame_ctrl.

Test Plan (CLKS_PER_BIT=10, DATA_BITS=8):
- Frame 0xA5 with stop=1, start accepted at offset 0 -> 8 shift_strobe pulses ending at edges 15,25,...,85; load_buffer high between edges 95 and 96; framing_error stays 0; busy falls at 95.
- Same frame with stop bit driven 0 -> 8 strobes, no load_buffer, framing_error rises at edge 95 and holds; a following good frame clears it at its offset-5 edge.
- Glitch: serial_sync back to 1 before offset 5 -> return to IDLE at edge 5, zero strobes, busy high for 5 cycles only.
- Extra start_bit_detected pulses at offsets 30 and 95 -> ignored; strobe timing identical to scenario 1; a pulse at offset 97 is accepted as a new frame.
- n_rst asserted at offset 42 (mid-RECV) -> all outputs 0 immediately; after release, IDLE, and a new frame receives normally.
- CLKS_PER_BIT=16, DATA_BITS=7 instance -> 7 strobes ending at edges 24,40,...,120; load_buffer at edge 136.
